// File: rtl/polyphase_serializer.sv
// Parallel-to-serial converter: one CPS-lane word in, one DW-bit sample per clock out, lane 0 first.
// Optional `OUT_LAST_EN adds an out_last flag marking the final lane of each word.
module polyphase_serializer #(
  parameter int unsigned CPS = 4,
  parameter int unsigned DW  = 16,
  localparam int unsigned LW = $clog2(CPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CPS*DW-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [LW-1:0]     out_lane
`ifdef OUT_LAST_EN
  ,
  output logic              out_last
`endif
);

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_TWO   = 2'd2
  } cnt_e;

  localparam logic [LW-1:0] LAST_LANE = LW'(CPS - 1);

  cnt_e              cnt_q, cnt_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [CPS*DW-1:0] act_q, act_d;
  logic [CPS*DW-1:0] pend_q, pend_d;
  logic              accept, xfer, retire;

  always_comb begin
    in_ready  = (cnt_q != CNT_TWO);
    out_valid = (cnt_q != CNT_EMPTY);
    out_data  = act_q[32'(lane_q) * DW +: DW];
    out_lane  = lane_q;
  end

`ifdef OUT_LAST_EN
  always_comb out_last = out_valid && (lane_q == LAST_LANE);
`endif

  always_comb begin
    accept = in_valid && in_ready;
    xfer   = out_valid && out_ready;
    retire = xfer && (lane_q == LAST_LANE);

    cnt_d  = cnt_q;
    lane_d = lane_q;
    act_d  = act_q;
    pend_d = pend_q;

    if (xfer) lane_d = retire ? '0 : lane_q + LW'(1);

    // Accept and retire on the same edge load the new word straight into act,
    // so the next cycle already shows its lane 0 with no bubble.
    case (cnt_q)
      CNT_EMPTY: begin
        if (accept) begin
          act_d = in_data;
          cnt_d = CNT_ONE;
        end
      end
      CNT_ONE: begin
        if (accept && retire) begin
          act_d = in_data;
        end else if (accept) begin
          pend_d = in_data;
          cnt_d  = CNT_TWO;
        end else if (retire) begin
          act_d = pend_q;
          cnt_d = CNT_EMPTY;
        end
      end
      CNT_TWO: begin
        if (retire) begin
          act_d = pend_q;
          cnt_d = CNT_ONE;
        end
      end
      default: cnt_d = CNT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT_EMPTY;
      lane_q <= '0;
      act_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lane_q <= lane_d;
      act_q  <= act_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_polyphase_serializer.sv
// Directed and stall-stream bench for polyphase_serializer (CPS=4, DW=16).
module tb_polyphase_serializer;
  localparam int unsigned CPS = 4;
  localparam int unsigned DW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [CPS*DW-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_lane;
`ifdef OUT_LAST_EN
  logic              out_last;
`endif

  int n_vec = 0;
  int n_err = 0;

  polyphase_serializer #(.CPS(CPS), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane)
`ifdef OUT_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream word w carries sample ((w+1)<<8 | lane) in each lane.
  function automatic logic [15:0] samp(input int w, input int l);
    return 16'(((w + 1) << 8) | l);
  endfunction

  function automatic logic [CPS*DW-1:0] word(input int w);
    logic [CPS*DW-1:0] r;
    for (int l = 0; l < int'(CPS); l++) r[l*DW +: DW] = samp(w, l);
    return r;
  endfunction

  // Feeds nw words with in_valid held high, checks every presented sample in order.
  task automatic stream(input int nw, input int stall_pct, input int max_cyc,
                        output int cyc, output int gaps);
    int wi, oi, lasts;
    wi = 0; oi = 0; lasts = 0; cyc = 0; gaps = 0;
    while (oi < nw * int'(CPS) && cyc < max_cyc) begin
      in_valid  = (wi < nw);
      in_data   = word(wi);
      out_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= 32'(stall_pct));
      if (out_valid) begin
        check("stream_data", 64'(out_data), 64'(samp(oi / int'(CPS), oi % int'(CPS))));
        check("stream_lane", 64'(out_lane), 64'(oi % int'(CPS)));
`ifdef OUT_LAST_EN
        check("stream_last", 64'(out_last), 64'((oi % int'(CPS)) == int'(CPS) - 1));
        if (out_ready && out_last) lasts++;
`endif
        if (out_ready) oi++;
      end else begin
`ifdef OUT_LAST_EN
        check("idle_last", 64'(out_last), 64'(0));
`endif
        if (oi > 0) gaps++;
      end
      if (in_valid && in_ready) wi++;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("stream_count", 64'(oi), 64'(nw * int'(CPS)));
`ifdef OUT_LAST_EN
    check("last_count", 64'(lasts), 64'(nw));
`endif
  endtask

  initial begin
    int cyc, gaps;
    logic [15:0] exp1 [4];
    exp1 = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    check("rst_out_data",  64'(out_data),  64'(0));
    check("rst_out_lane",  64'(out_lane),  64'(0));
    step(); step();
    rst = 1'b0;
    step();

    // single word
    in_data = 64'h0004_0003_0002_0001; in_valid = 1'b1; out_ready = 1'b1;
    check("single_in_ready", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0; in_data = '0;
    for (int k = 0; k < 4; k++) begin
      check("single_valid", 64'(out_valid), 64'(1));
      check("single_data",  64'(out_data),  64'(exp1[k]));
      check("single_lane",  64'(out_lane),  64'(k));
      step();
    end
    check("single_done_valid", 64'(out_valid), 64'(0));

    // three words back to back: first sample one cycle after first accept, 12 samples no gap
    stream(3, 0, 100, cyc, gaps);
    check("stream3_gaps",   64'(gaps), 64'(0));
    check("stream3_cycles", 64'(cyc),  64'(13));
    check("stream3_idle",   64'(out_valid), 64'(0));

    // backpressure: two words fill the buffer, output frozen at word0 lane0
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA003_A002_A001_A000;
    step();
    check("bp_accept2_ready", 64'(in_ready), 64'(1));
    in_data = 64'hB003_B002_B001_B000;
    step();
    for (int k = 0; k < 3; k++) begin
      check("bp_full_ready", 64'(in_ready),  64'(0));
      check("bp_freeze_data", 64'(out_data), 64'(16'hA000));
      check("bp_freeze_lane", 64'(out_lane), 64'(0));
      in_data = 64'hEEEE_EEEE_EEEE_EEEE;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("bp_drain_valid", 64'(out_valid), 64'(1));
      check("bp_drain_data",  64'(out_data),  64'(((k < 4) ? 16'hA000 : 16'hB000) | 16'(k % 4)));
      check("bp_drain_ready", 64'(in_ready),  64'(k >= 4));
      step();
    end
    check("bp_drain_idle", 64'(out_valid), 64'(0));

    // reset with the buffer full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h1111_1111_1111_1111;
    step(); step();
    check("rstmid_full", 64'(in_ready), 64'(0));
    rst = 1'b1;
    #1;
    check("rstmid_out_valid", 64'(out_valid), 64'(0));
    check("rstmid_in_ready",  64'(in_ready),  64'(1));
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("rstmid_idle", 64'(out_valid), 64'(0));
    in_valid = 1'b1; in_data = 64'hD003_D002_D001_D000; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("rstmid_first_data", 64'(out_data), 64'(16'hD000));
    check("rstmid_first_lane", 64'(out_lane), 64'(0));
    step(); step(); step(); step();
    check("rstmid_done", 64'(out_valid), 64'(0));

    // random stall over 100 words
    stream(100, 50, 5000, cyc, gaps);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
